// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the game sequencer, the graphics
// compositor and the depth-sprite blocks.
//   game_state_t      - encoded round state driven to the graphics path
//   wall_view_t       - registered display payload (state/depth/index/visible)
//   DEFAULT_*         - default depth and judgement-window constants
//   in_goal_window()  - inclusive window test on a wall depth
package game_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned DEPTH_W = 8;
    localparam int unsigned INDEX_W = 4;
    localparam int unsigned COLL_W  = 16;

    localparam int unsigned DEFAULT_MAX_WALL_DEPTH   = 75;
    localparam int unsigned DEFAULT_GOAL_DEPTH       = 60;
    localparam int unsigned DEFAULT_GOAL_DEPTH_DELTA = 10;

    typedef enum logic [STATE_W-1:0] {
        GAME_OVER        = 3'd0,
        GAME_IN_PROGRESS = 3'd1,
        GAME_WIN         = 3'd2,
        COUNTDOWN        = 3'd3
    } game_state_t;

    typedef struct packed {
        game_state_t          state;
        logic [DEPTH_W-1:0]   depth;
        logic [INDEX_W-1:0]   index;
        logic                 visible;
    } wall_view_t;

    // Written as depth+delta >= goal so a delta larger than goal cannot wrap.
    function automatic logic in_goal_window(
        input logic [DEPTH_W-1:0] depth,
        input int unsigned        goal,
        input int unsigned        delta
    );
        return ((32'(depth) + delta) >= goal) && (32'(depth) <= (goal + delta));
    endfunction

endpackage

// File: rtl/frame_collision_counter.sv
// frame_collision_counter: saturating per-frame count of collision pixels.
//   clk, rst_n   - clock, async active-low reset
//   frame_tick   - end-of-frame pulse: capture the count, restart the frame
//   hit          - current pixel is an active-region collision
//   live_count   - count accumulated so far in the current frame
//   frame_count  - count of the last completed frame
module frame_collision_counter
    import game_pkg::*;
#(
    parameter int unsigned W = COLL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_tick,
    input  logic         hit,
    output logic [W-1:0] live_count,
    output logic [W-1:0] frame_count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // A hit on the tick cycle belongs to the frame that starts there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_count  <= '0;
            frame_count <= '0;
        end else if (frame_tick) begin
            frame_count <= live_count;
            live_count  <= W'(hit);
        end else if (hit && (live_count != CNT_MAX)) begin
            live_count  <= live_count + W'(1);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: frame-rate controller for the hole-in-the-wall round.
// Owns game state, wall depth/index and the per-frame collision judgement;
// every display-visible change is applied on a frame tick or a start edge.
//   clk_in, rst_n_in      - pixel clock, async active-low reset
//   frame_tick_in         - one-cycle pulse at end of active video
//   pixel_valid_in        - current pixel is in the active region
//   is_collision_in       - current pixel is a player/wall collision
//   start_in              - synchronized, debounced start level
//   game_state_out        - 0 over, 1 in progress, 2 win, 3 countdown
//   wall_depth_out        - current wall depth
//   wall_index_out        - current wall number (0-based)
//   wall_visible_out      - wall is rendered
//   frame_collisions_out  - collision count of the last completed frame
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned NUM_WALLS           = 4,
    parameter int unsigned MAX_WALL_DEPTH      = DEFAULT_MAX_WALL_DEPTH,
    parameter int unsigned GOAL_DEPTH          = DEFAULT_GOAL_DEPTH,
    parameter int unsigned GOAL_DEPTH_DELTA    = DEFAULT_GOAL_DEPTH_DELTA,
    parameter int unsigned FRAMES_PER_STEP     = 4,
    parameter int unsigned COUNTDOWN_FRAMES    = 60,
    parameter int unsigned COLLISION_THRESHOLD = 500
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               frame_tick_in,
    input  logic               pixel_valid_in,
    input  logic               is_collision_in,
    input  logic               start_in,
    output logic [STATE_W-1:0] game_state_out,
    output logic [DEPTH_W-1:0] wall_depth_out,
    output logic [INDEX_W-1:0] wall_index_out,
    output logic               wall_visible_out,
    output logic [COLL_W-1:0]  frame_collisions_out
);

    localparam int unsigned STEP_W = (FRAMES_PER_STEP > 1)  ? $clog2(FRAMES_PER_STEP)  : 1;
    localparam int unsigned CD_W   = (COUNTDOWN_FRAMES > 1) ? $clog2(COUNTDOWN_FRAMES) : 1;

    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [CD_W-1:0]    CD_LAST    = CD_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(MAX_WALL_DEPTH);
    localparam logic [INDEX_W-1:0] INDEX_LAST = INDEX_W'(NUM_WALLS - 1);

    wall_view_t          view_q, view_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CD_W-1:0]     cd_q, cd_d;
    logic                start_prev_q;
    logic                start_edge_q;
    logic [COLL_W-1:0]   live_count;
    logic [COLL_W-1:0]   frame_count;
    logic                frame_failed_c;

    // Collision counting runs in every state; only IN_PROGRESS judges it.
    frame_collision_counter #(
        .W (COLL_W)
    ) u_frame_collision_counter (
        .clk         (clk_in),
        .rst_n       (rst_n_in),
        .frame_tick  (frame_tick_in),
        .hit         (pixel_valid_in & is_collision_in),
        .live_count  (live_count),
        .frame_count (frame_count)
    );

    // Registered start edge: costs one cycle but keeps start_in off the FSM path.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            start_prev_q <= 1'b0;
            start_edge_q <= 1'b0;
        end else begin
            start_prev_q <= start_in;
            start_edge_q <= start_in & ~start_prev_q;
        end
    end

    // live_count still holds the just-finished frame on the tick cycle.
    assign frame_failed_c = in_goal_window(view_q.depth, GOAL_DEPTH, GOAL_DEPTH_DELTA)
                            && (32'(live_count) > COLLISION_THRESHOLD);

    // State and counter registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            view_q <= '0;
            step_q <= '0;
            cd_q   <= '0;
        end else begin
            view_q <= view_d;
            step_q <= step_d;
            cd_q   <= cd_d;
        end
    end

    // Next-state logic: only start edges and frame ticks cause changes.
    always_comb begin
        view_d = view_q;
        step_d = step_q;
        cd_d   = cd_q;

        case (view_q.state)
            GAME_OVER, GAME_WIN: begin
                if (start_edge_q) begin
                    view_d.state   = COUNTDOWN;
                    view_d.depth   = '0;
                    view_d.index   = '0;
                    view_d.visible = 1'b0;
                    step_d         = '0;
                    cd_d           = '0;
                end
            end

            COUNTDOWN: begin
                if (frame_tick_in) begin
                    if (cd_q == CD_LAST) begin
                        view_d.state   = GAME_IN_PROGRESS;
                        view_d.depth   = '0;
                        view_d.visible = 1'b1;
                        step_d         = '0;
                        cd_d           = '0;
                    end else begin
                        cd_d = cd_q + CD_W'(1);
                    end
                end
            end

            GAME_IN_PROGRESS: begin
                if (frame_tick_in) begin
                    if (frame_failed_c) begin
                        view_d.state = GAME_OVER;
                    end else if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (view_q.depth >= DEPTH_LAST) begin
                            if (view_q.index >= INDEX_LAST) begin
                                view_d.state = GAME_WIN;
                            end else begin
                                view_d.state   = COUNTDOWN;
                                view_d.index   = view_q.index + INDEX_W'(1);
                                view_d.depth   = '0;
                                view_d.visible = 1'b0;
                                cd_d           = '0;
                            end
                        end else begin
                            view_d.depth = view_q.depth + DEPTH_W'(1);
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end

            default: begin
                view_d.state = GAME_OVER;
            end
        endcase
    end

    assign game_state_out       = view_q.state;
    assign wall_depth_out       = view_q.depth;
    assign wall_index_out       = view_q.index;
    assign wall_visible_out     = view_q.visible;
    assign frame_collisions_out = frame_count;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard bench for game_sequencer with small parameters
// (2 frames/step, 3 countdown frames, 2 walls, threshold 100).
module tb_game_sequencer;

    localparam logic [2:0] ST_OVER = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_WIN  = 3'd2;
    localparam logic [2:0] ST_CD   = 3'd3;

    localparam logic [3:0] M_DEP = 4'b0001;
    localparam logic [3:0] M_IDX = 4'b0010;
    localparam logic [3:0] M_VIS = 4'b0100;
    localparam logic [3:0] M_COL = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick  = 1'b0;
    logic        pv    = 1'b0;
    logic        ic    = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  game_state;
    logic [7:0]  wall_depth;
    logic [3:0]  wall_index;
    logic        wall_visible;
    logic [15:0] frame_coll;

    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string       name;
        int unsigned due;
        logic [3:0]  mask;
        logic [2:0]  st;
        logic [7:0]  dep;
        logic [3:0]  idx;
        logic        vis;
        logic [15:0] col;
    } exp_t;

    typedef struct {
        int         depth;
        int         hits;
        logic [2:0] st;
    } row_t;

    exp_t sb_q[$];
    row_t rows[6];

    game_sequencer #(
        .NUM_WALLS           (2),
        .MAX_WALL_DEPTH      (75),
        .GOAL_DEPTH          (60),
        .GOAL_DEPTH_DELTA    (10),
        .FRAMES_PER_STEP     (2),
        .COUNTDOWN_FRAMES    (3),
        .COLLISION_THRESHOLD (100)
    ) dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .frame_tick_in        (tick),
        .pixel_valid_in       (pv),
        .is_collision_in      (ic),
        .start_in             (start),
        .game_state_out       (game_state),
        .wall_depth_out       (wall_depth),
        .wall_index_out       (wall_index),
        .wall_visible_out     (wall_visible),
        .frame_collisions_out (frame_coll)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input exp_t e);
        logic ok;
        ok = (game_state == e.st);
        if (e.mask[0] && (wall_depth   != e.dep)) ok = 1'b0;
        if (e.mask[1] && (wall_index   != e.idx)) ok = 1'b0;
        if (e.mask[2] && (wall_visible != e.vis)) ok = 1'b0;
        if (e.mask[3] && (frame_coll   != e.col)) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d: got state=%0d depth=%0d index=%0d visible=%0d coll=%0d; want state=%0d depth=%0d index=%0d visible=%0d coll=%0d (mask %b)",
                     e.name, cyc, game_state, wall_depth, wall_index, wall_visible, frame_coll,
                     e.st, e.dep, e.idx, e.vis, e.col, e.mask);
        end
    endtask

    task automatic push(input string name, input int unsigned lat, input logic [3:0] mask,
                        input logic [2:0] st, input logic [7:0] dep, input logic [3:0] idx,
                        input logic vis, input logic [15:0] col);
        exp_t e;
        e.name = name; e.due = cyc + lat; e.mask = mask;
        e.st = st; e.dep = dep; e.idx = idx; e.vis = vis; e.col = col;
        sb_q.push_back(e);
    endtask

    // Outputs are compared on the falling edge once their due cycle is reached.
    always @(negedge clk) begin
        while ((sb_q.size() > 0) && (sb_q[0].due <= cyc)) begin
            compare(sb_q.pop_front());
        end
    end

    task automatic quiet();
        tick = 1'b0; pv = 1'b0; ic = 1'b0;
    endtask

    // One frame: a valid non-collision pixel, an out-of-region collision,
    // 'hits' counted pixels, then the tick (left high for the caller to push).
    task automatic frame(input int hits, input bit hit_on_tick);
        @(negedge clk); quiet(); pv = 1'b1;
        @(negedge clk); pv = 1'b0; ic = 1'b1;
        for (int i = 0; i < hits; i++) begin
            @(negedge clk); pv = 1'b1; ic = 1'b1;
        end
        @(negedge clk); pv = hit_on_tick; ic = hit_on_tick; tick = 1'b1;
    endtask

    task automatic start_press(input logic [2:0] st_before, input logic [2:0] st_after,
                               input logic [3:0] mask, input logic [7:0] dep,
                               input logic [3:0] idx, input logic vis);
        @(negedge clk); quiet(); start = 1'b1;
        push("start_t1", 1, 4'b0000, st_before, 8'd0, 4'd0, 1'b0, 16'd0);
        push("start_t2", 2, mask, st_after, dep, idx, vis, 16'd0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk); quiet(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic countdown(input logic [3:0] idx);
        frame(0, 0); push("cd_1", 1, M_VIS | M_IDX, ST_CD, 8'd0, idx, 1'b0, 16'd0);
        frame(0, 0); push("cd_2", 1, M_VIS | M_IDX, ST_CD, 8'd0, idx, 1'b0, 16'd0);
        frame(0, 0); push("cd_go", 1, M_ALL, ST_RUN, 8'd0, idx, 1'b1, 16'd0);
    endtask

    // Ticks 1..151 of a wall: depth = ticks/2, reaching 75 without completing.
    task automatic run_wall(input logic [3:0] idx);
        for (int k = 1; k <= 151; k++) begin
            frame(0, 0);
            push("wall_depth", 1, M_DEP | M_IDX | M_VIS, ST_RUN, 8'(k / 2), idx, 1'b1, 16'd0);
            if ((idx == 4'd0) && (k == 2))
                start_press(ST_RUN, ST_RUN, M_DEP, 8'd1, idx, 1'b1);
        end
    endtask

    initial begin
        exp_t z;
        z.mask = M_ALL; z.st = ST_OVER; z.dep = '0; z.idx = '0; z.vis = 1'b0; z.col = '0;

        rows[0] = '{55, 100, ST_RUN};
        rows[1] = '{55, 101, ST_OVER};
        rows[2] = '{49, 101, ST_RUN};
        rows[3] = '{50, 101, ST_OVER};
        rows[4] = '{70, 101, ST_OVER};
        rows[5] = '{71, 101, ST_RUN};

        #2 rst_n = 1'b0;
        #2 z.name = "reset_state"; z.due = cyc; compare(z);
        @(negedge clk); rst_n = 1'b1;

        // Full round: countdown, two walls, win, restart from win.
        start_press(ST_OVER, ST_CD, M_ALL, 8'd0, 4'd0, 1'b0);
        countdown(4'd0);
        run_wall(4'd0);
        frame(0, 0); push("wall0_done", 1, M_IDX | M_VIS, ST_CD, 8'd0, 4'd1, 1'b0, 16'd0);
        countdown(4'd1);
        run_wall(4'd1);
        frame(0, 0); push("win", 1, M_DEP | M_IDX, ST_WIN, 8'd75, 4'd1, 1'b0, 16'd0);
        frame(0, 0); push("win_hold", 1, M_DEP | M_IDX, ST_WIN, 8'd75, 4'd1, 1'b0, 16'd0);
        start_press(ST_WIN, ST_CD, M_DEP | M_IDX | M_VIS, 8'd0, 4'd0, 1'b0);

        // Advance to depth 40 with a 5-hit frame last, then reset mid-frame.
        countdown(4'd0);
        for (int k = 1; k <= 79; k++) frame(0, 0);
        frame(5, 0); push("depth40", 1, M_DEP | M_COL, ST_RUN, 8'd40, 4'd0, 1'b1, 16'd5);
        @(negedge clk); quiet(); pv = 1'b1; ic = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 z.name = "async_reset"; z.due = cyc; compare(z);
        @(negedge clk); quiet(); rst_n = 1'b1;
        frame(4, 1); push("coll_count", 1, M_COL, ST_OVER, 8'd0, 4'd0, 1'b0, 16'd4);
        frame(0, 0); push("coll_tick_px", 1, M_COL, ST_OVER, 8'd0, 4'd0, 1'b0, 16'd1);

        // Judgement window / threshold boundaries.
        foreach (rows[r]) begin
            reset_pulse();
            start_press(ST_OVER, ST_CD, M_ALL, 8'd0, 4'd0, 1'b0);
            countdown(4'd0);
            for (int k = 0; k < 2 * rows[r].depth; k++) frame(0, 0);
            frame(rows[r].hits, 0);
            push("judge", 1, M_DEP | M_COL, rows[r].st, 8'(rows[r].depth), 4'd0, 1'b0,
                 16'(rows[r].hits));
        end

        // Saturation of the per-frame counter.
        reset_pulse();
        frame(70000, 0); push("saturate", 1, M_COL, ST_OVER, 8'd0, 4'd0, 1'b0, 16'hFFFF);
        frame(0, 0); push("sat_clear", 1, M_COL, ST_OVER, 8'd0, 4'd0, 1'b0, 16'd0);

        @(negedge clk); quiet();
        repeat (3) @(negedge clk);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation due at cyc %0d never compared (now %0d)", e.name, e.due, cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
